// File: rtl/mat_mul_sequencer_if.sv
// ---------------------------------------------------------------------------
// mat_mul_sequencer_if
//   Bundles the operand load port, run control, tree operand/result bus and
//   the result stream of mat_mul_sequencer.
//
//   Ports grouped here:
//     ld_valid/ld_ready/ld_sel/ld_row/ld_col/ld_data  element load handshake
//     start/busy/done                                 run control and status
//     Row_out/Col_out                                 operand vectors to tree
//     tree_result                                     tree output
//     res_valid/res_row/res_col/res_data              result stream C[i][j]
//
//   Modports:
//     slave  - the sequencer's view (drives status, operands, results)
//     master - the environment's view (drives loads, start, tree_result)
// ---------------------------------------------------------------------------
interface mat_mul_sequencer_if #(
  parameter int MATRIX_SIZE = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 16
) ();

  localparam int IDX_W = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;

  logic                              ld_valid;
  logic                              ld_ready;
  logic                              ld_sel;
  logic [IDX_W-1:0]                  ld_row;
  logic [IDX_W-1:0]                  ld_col;
  logic [DATA_WIDTH-1:0]             ld_data;

  logic                              start;
  logic                              busy;
  logic                              done;

  logic [MATRIX_SIZE*DATA_WIDTH-1:0] Row_out;
  logic [MATRIX_SIZE*DATA_WIDTH-1:0] Col_out;
  logic [ACC_WIDTH-1:0]              tree_result;

  logic                              res_valid;
  logic [IDX_W-1:0]                  res_row;
  logic [IDX_W-1:0]                  res_col;
  logic [ACC_WIDTH-1:0]              res_data;

  modport slave (
    input  ld_valid, ld_sel, ld_row, ld_col, ld_data, start, tree_result,
    output ld_ready, busy, done, Row_out, Col_out,
           res_valid, res_row, res_col, res_data
  );

  modport master (
    output ld_valid, ld_sel, ld_row, ld_col, ld_data, start, tree_result,
    input  ld_ready, busy, done, Row_out, Col_out,
           res_valid, res_row, res_col, res_data
  );

endinterface

// File: rtl/mat_mul_sequencer.sv
// ---------------------------------------------------------------------------
// mat_mul_sequencer
//   Upstream driver for an NxN signed multiply/adder-tree datapath. Holds
//   operand matrices A and B (written one element per cycle while idle),
//   and on start presents one (row i of A, column j of B) pair per cycle in
//   row-major order. A tag pipeline matched to the tree latency attaches
//   the (i, j) indices to each tree result as it emerges.
//
//   Ports:
//     clk          rising-edge clock
//     rst          synchronous, active-high reset
//     bus (slave)  load port, start/busy/done, Row_out/Col_out to the tree,
//                  tree_result from the tree, res_* result stream
//     cycle_count  (only with MMS_CYCLE_CNT_EN) cycles spent busy in the
//                  most recent run
//
//   Build option:
//     MMS_CYCLE_CNT_EN  when defined, adds the cycle_count output port and
//                       its counter; otherwise both are absent.
//
//   Timing (start accepted in cycle 0, N=4, PIPE_LATENCY=3):
//     Row_out/Col_out valid cycles 1..16, res_valid cycles 5..20,
//     done in cycle 20, busy low again in cycle 21.
// ---------------------------------------------------------------------------
module mat_mul_sequencer #(
  parameter int MATRIX_SIZE  = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int ACC_WIDTH    = 16,
  parameter int PIPE_LATENCY = 3
) (
  input  logic                clk,
  input  logic                rst,
  mat_mul_sequencer_if.slave  bus
`ifdef MMS_CYCLE_CNT_EN
  ,
  output logic [31:0]         cycle_count
`endif
);

  localparam int N  = MATRIX_SIZE;
  localparam int DW = DATA_WIDTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Index tag that travels alongside an operand pair through the tree.
  typedef struct packed {
    logic          vld;
    logic [IW-1:0] i;
    logic [IW-1:0] j;
  } tag_t;

  // Operand buffers; deliberately not reset so a reset keeps loaded data.
  logic [DW-1:0] a_mem_r [N][N];
  logic [DW-1:0] b_mem_r [N][N];

  state_t            state_r;
  state_t            state_nx_s;

  // Indices of the pair currently on Row_out/Col_out (valid when issue_vld_r).
  logic [IW-1:0]     cur_i_r;
  logic [IW-1:0]     cur_j_r;
  logic              issue_vld_r;
  logic [IW-1:0]     nxt_i_s;
  logic [IW-1:0]     nxt_j_s;
  logic              issue_nx_s;
  logic              last_pair_s;
  logic              ld_we_s;
  logic              pipe_busy_s;

  logic [N*DW-1:0]   row_out_r;
  logic [N*DW-1:0]   col_out_r;
  logic [N*DW-1:0]   row_nx_s;
  logic [N*DW-1:0]   col_nx_s;

  tag_t              pipe_r [PIPE_LATENCY];

  logic              res_valid_r;
  logic [IW-1:0]     res_row_r;
  logic [IW-1:0]     res_col_r;
  logic [ACC_WIDTH-1:0] res_data_r;
  logic              done_r;
  logic              busy_r;
  logic              ld_ready_r;

  assign last_pair_s = (cur_i_r == IW'(N-1)) && (cur_j_r == IW'(N-1));

  // Next-state logic: load enable, issue sequencing and run completion.
  always_comb begin
    state_nx_s = state_r;
    issue_nx_s = 1'b0;
    nxt_i_s    = cur_i_r;
    nxt_j_s    = cur_j_r;
    ld_we_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        ld_we_s = bus.ld_valid;
        if (bus.start) begin
          state_nx_s = ST_ISSUE;
          issue_nx_s = 1'b1;
          nxt_i_s    = '0;
          nxt_j_s    = '0;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (last_pair_s) begin
          state_nx_s = ST_DRAIN;
        end else begin
          issue_nx_s = 1'b1;
          if (cur_j_r == IW'(N-1)) begin
            nxt_i_s = cur_i_r + IW'(1);
            nxt_j_s = '0;
          end else begin
            nxt_j_s = cur_j_r + IW'(1);
          end
        end
      end
      ST_DRAIN: begin
        // done_r marks the cycle the final result is on the outputs.
        if (done_r && !pipe_busy_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Tag pipe occupancy, including the pair currently being presented.
  always_comb begin
    pipe_busy_s = issue_vld_r;
    for (int k = 0; k < PIPE_LATENCY; k++) begin
      pipe_busy_s = pipe_busy_s | pipe_r[k].vld;
    end
  end

  // Operand vectors for the next pair. A load in the start cycle is
  // forwarded so the first issue already sees the freshly written element.
  always_comb begin
    row_nx_s = '0;
    col_nx_s = '0;
    if (issue_nx_s) begin
      for (int k = 0; k < N; k++) begin
        row_nx_s[k*DW +: DW] =
          (ld_we_s && !bus.ld_sel && (bus.ld_row == nxt_i_s) && (bus.ld_col == IW'(k)))
            ? bus.ld_data : a_mem_r[nxt_i_s][k];
        col_nx_s[k*DW +: DW] =
          (ld_we_s && bus.ld_sel && (bus.ld_row == IW'(k)) && (bus.ld_col == nxt_j_s))
            ? bus.ld_data : b_mem_r[k][nxt_j_s];
      end
    end else begin
      row_nx_s = '0;
      col_nx_s = '0;
    end
  end

  // Operand buffer writes, accepted only while idle and out of reset.
  always_ff @(posedge clk) begin
    if (!rst && ld_we_s) begin
      if (bus.ld_sel) begin
        b_mem_r[bus.ld_row][bus.ld_col] <= bus.ld_data;
      end else begin
        a_mem_r[bus.ld_row][bus.ld_col] <= bus.ld_data;
      end
    end
  end

  // FSM state, issue registers, tag pipe and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cur_i_r     <= '0;
      cur_j_r     <= '0;
      issue_vld_r <= 1'b0;
      row_out_r   <= '0;
      col_out_r   <= '0;
      for (int k = 0; k < PIPE_LATENCY; k++) begin
        pipe_r[k] <= '0;
      end
      res_valid_r <= 1'b0;
      res_row_r   <= '0;
      res_col_r   <= '0;
      res_data_r  <= '0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      ld_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_nx_s;
      cur_i_r     <= nxt_i_s;
      cur_j_r     <= nxt_j_s;
      issue_vld_r <= issue_nx_s;
      row_out_r   <= row_nx_s;
      col_out_r   <= col_nx_s;
      // Stage 0 holds the tag one cycle after its operands were presented,
      // so the last stage lines up with tree_result.
      pipe_r[0]   <= '{vld: issue_vld_r, i: cur_i_r, j: cur_j_r};
      for (int k = 1; k < PIPE_LATENCY; k++) begin
        pipe_r[k] <= pipe_r[k-1];
      end
      res_valid_r <= pipe_r[PIPE_LATENCY-1].vld;
      if (pipe_r[PIPE_LATENCY-1].vld) begin
        res_row_r  <= pipe_r[PIPE_LATENCY-1].i;
        res_col_r  <= pipe_r[PIPE_LATENCY-1].j;
        res_data_r <= bus.tree_result;
      end
      done_r      <= pipe_r[PIPE_LATENCY-1].vld &&
                     (pipe_r[PIPE_LATENCY-1].i == IW'(N-1)) &&
                     (pipe_r[PIPE_LATENCY-1].j == IW'(N-1));
      busy_r      <= (state_nx_s != ST_IDLE);
      ld_ready_r  <= (state_nx_s == ST_IDLE);
    end
  end

`ifdef MMS_CYCLE_CNT_EN
  logic [31:0] cyc_cnt_r;

  // Busy-cycle counter: restarts on each accepted start, holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt_r <= 32'd0;
    end else if ((state_r == ST_IDLE) && bus.start) begin
      cyc_cnt_r <= 32'd0;
    end else if (busy_r) begin
      cyc_cnt_r <= cyc_cnt_r + 32'd1;
    end else begin
      cyc_cnt_r <= cyc_cnt_r;
    end
  end

  assign cycle_count = cyc_cnt_r;
`endif

  assign bus.ld_ready  = ld_ready_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.Row_out   = row_out_r;
  assign bus.Col_out   = col_out_r;
  assign bus.res_valid = res_valid_r;
  assign bus.res_row   = res_row_r;
  assign bus.res_col   = res_col_r;
  assign bus.res_data  = res_data_r;

endmodule
